fifo_fwft_sync: RTL and testbench
=================================

// Module: fifo_fwft_sync
// PURPOSE
//  Single-clock first-word-fall-through FIFO. Sits directly upstream of the FWFT
//  reader stage in the FIFO bench and in RTL consumers.
//  - Storage: dual-port RAM plus one output (prefetch) register.
//  - Output protocol: dout is valid whenever empty=0; rd_en acknowledges (pops)
//    the presented word.
// PARAMETERS
//  WIDTH       8   data word width in bits (must be >=1)
//  ADDR_WIDTH  4   RAM address bits; RAM depth = 2**ADDR_WIDTH
//                  total capacity = 2**ADDR_WIDTH+1 (RAM + output register)
// PORTS
//  clk    in   1                 rising-edge clock
//  rst    in   1                 asynchronous active-high reset
//  din    in   WIDTH             write data
//  wr_en  in   1                 write request, sampled at posedge clk
//  full   out  1                 RAM full; writes are dropped while high
//  dout   out  WIDTH             head-of-FIFO word; valid while empty=0
//  rd_en  in   1                 pop request; ignored while empty=1
//  empty  out  1                 no word presented on dout
//  level  out  ADDR_WIDTH+1      occupancy (only with FIFO_FWFT_LEVEL_EN)
// BEHAVIOUR
//  - Reset (async, asserted): wr_ptr=rd_ptr=0, ram_count=0, empty=1, full=0,
//    dout=0, level=0. RAM contents undefined. Asserting rst mid-operation drops
//    all stored words immediately.
//  - Write: wr_en & !full -> RAM[wr_ptr]<=din; wr_ptr+1 (wraps mod 2**ADDR_WIDTH).
//    wr_en & full -> word dropped, no state change.
//  - Prefetch: when the output register is empty, or is being popped this cycle,
//    and ram_count>0 -> synchronous RAM read of RAM[rd_ptr]; rd_ptr+1;
//    word lands in the output register at the same edge.
//  - Read: rd_en & !empty pops the output register. If RAM is empty and no
//    prefetch occurs, empty=1 after that edge.
//  - Latency: write at edge E0 into an empty FIFO -> empty=0 and dout=word after
//    edge E1. A write in the same cycle as a pop of the last word follows the
//    same path: one bubble cycle with empty=1.
//  - ram_count update: +1 on accepted write, -1 on prefetch; both in the same
//    cycle -> unchanged. full = (ram_count == 2**ADDR_WIDTH), registered.
//  - Read-during-write to the same RAM address cannot occur: prefetch requires
//    ram_count>0 before the edge.
//  - Order: strict FIFO; no reordering, no duplication, no loss of any
//    accepted word.
//  - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  FIFO_FWFT_LEVEL_EN defined:
//    - level = ram_count + (!empty), registered, updated on the same edges
//      as empty/full.
//    - Range 0..2**ADDR_WIDTH+1.
//  FIFO_FWFT_LEVEL_EN undefined:
//    - level port absent; no occupancy adder is built.
//    - All other behaviour is identical.
// STRUCTURE
//  fifo_pkg:
//    - function clog2
//    - localparam RAM_LATENCY=1
//    - shared pointer-increment helper
//  Sub-module fifo_ram_sdp:
//    - simple dual-port RAM, one write port, one read port
//    - registered read with read enable, no reset on the data path
//  Top level:
//    - pointers, ram_count and full logic
//    - prefetch/output register and empty flag
//    - optional level output
// TESTING (WIDTH=8, ADDR_WIDTH=2; capacity 5)
//  1. Reset, idle 3 cycles -> empty=1, full=0, dout=0, level=0.
//  2. Write 0xA5 at E0, rd_en=0 -> empty=1 after E0, empty=0 with dout=0xA5
//     after E1; rd_en=1 for one cycle -> empty=1.
//  3. Write 0x01..0x06 back-to-back, rd_en=0:
//     - full=1 after the 5th write.
//     - 0x06 dropped; level=5.
//     - Popping all words yields 0x01..0x05, then empty=1.
//  4. rd_en=1 while empty for 10 cycles -> no state change, no pointer
//     movement, level=0.
//  5. Simultaneous wr_en/rd_en every cycle for 20 words at steady state
//     (2 words held) -> output order matches input, level stays 2, full never
//     asserts.
//  6. Fill 3 words, assert rst mid-cycle asynchronously -> empty=1, full=0
//     immediately; a write after release -> dout equals the new word, not old
//     data.
//  Random: fifo_fwft_reader at rate 0.5 plus a random writer, 1000 words,
//  scoreboard compare, no timeout.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FWFT FIFO
package fifo_pkg;

  localparam int RAM_LATENCY = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Pointer increment wrapping modulo 2**aw.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int aw);
    return (ptr + 32'd1) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple dual-port RAM with registered, enabled read
module fifo_ram_sdp #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_fwft_sync.sv
// rtl/fifo_fwft_sync.sv - single-clock first-word-fall-through FIFO
// Optional occupancy output enabled by FIFO_FWFT_LEVEL_EN.
module fifo_fwft_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic                  wr_en,
  output logic                  full,
  output logic [WIDTH-1:0]      dout,
  input  logic                  rd_en,
  output logic                  empty
`ifdef FIFO_FWFT_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         ram_count;
  logic [CW-1:0]         count_next;
  logic                  empty_next;
  logic                  wr_acc;
  logic                  pop;
  logic                  prefetch;
  logic                  loaded;
  logic [WIDTH-1:0]      rdata;

  always_comb begin
    wr_acc     = wr_en & ~full;
    pop        = rd_en & ~empty;
    prefetch   = (empty | pop) & (ram_count != '0);
    count_next = ram_count + CW'(wr_acc) - CW'(prefetch);
    empty_next = prefetch ? 1'b0 : (pop ? 1'b1 : empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      loaded    <= 1'b0;
    end else begin
      if (wr_acc)   wr_ptr <= ADDR_WIDTH'(ptr_inc(32'(wr_ptr), ADDR_WIDTH));
      if (prefetch) rd_ptr <= ADDR_WIDTH'(ptr_inc(32'(rd_ptr), ADDR_WIDTH));
      ram_count <= count_next;
      full      <= (count_next == CW'(DEPTH));
      empty     <= empty_next;
      loaded    <= loaded | prefetch;
    end
  end

  // The RAM read register doubles as the output register; it has no reset,
  // so dout is forced to zero until the first word has been fetched.
  assign dout = loaded ? rdata : '0;

  if (RAM_LATENCY == 1) begin : g_ram
    fifo_ram_sdp #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (din),
      .re    (prefetch),
      .raddr (rd_ptr),
      .rdata (rdata)
    );
  end

`ifdef FIFO_FWFT_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level <= '0;
    else     level <= (ADDR_WIDTH+1)'(count_next) + (ADDR_WIDTH+1)'(~empty_next);
  end
`endif

endmodule

// File: tb/tb_fifo_fwft_sync.sv
// tb/tb_fifo_fwft_sync.sv - scoreboard bench for fifo_fwft_sync (WIDTH=8, ADDR_WIDTH=2)
module tb_fifo_fwft_sync;

  localparam int RAM_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full;
  logic       empty;
  logic [7:0] dout;
`ifdef FIFO_FWFT_LEVEL_EN
  logic [2:0] level;
`endif

  fifo_fwft_sync #(.WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr_en (wr_en),
    .full  (full),
    .dout  (dout),
    .rd_en (rd_en),
    .empty (empty)
`ifdef FIFO_FWFT_LEVEL_EN
    ,
    .level (level)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference model: words waiting in RAM, plus whether a word is presented.
  logic [7:0] exp_q[$];
  int         m_ram = 0;
  bit         m_head = 1'b0;
  int         accepted = 0;
  bit         m_acc, m_pop, m_pf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_ram  = 0;
      m_head = 1'b0;
    end else begin
      m_acc = wr_en && (m_ram < RAM_DEPTH);
      m_pop = rd_en && m_head;
      m_pf  = (!m_head || m_pop) && (m_ram > 0);
      m_ram = m_ram + (m_acc ? 1 : 0) - (m_pf ? 1 : 0);
      if (m_acc) begin
        exp_q.push_back(din);
        accepted++;
      end
      m_head = m_pf ? 1'b1 : (m_pop ? 1'b0 : m_head);
    end
  end

  // Monitor: flags every cycle, data whenever the DUT presents a word being popped.
  always @(negedge clk) begin
    if (!rst) begin
      check("empty", int'(empty), int'(!m_head));
      check("full", int'(full), int'(m_ram == RAM_DEPTH));
`ifdef FIFO_FWFT_LEVEL_EN
      check("level", int'(level), m_ram + int'(m_head));
`endif
      if (!empty && rd_en) begin
        if (exp_q.size() == 0) check("pop_without_expected_word", 1, 0);
        else check("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int target;
  int guard;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    repeat (3) step();
    check("reset_empty", int'(empty), 1);
    check("reset_full", int'(full), 0);
    check("reset_dout", int'(dout), 0);
`ifdef FIFO_FWFT_LEVEL_EN
    check("reset_level", int'(level), 0);
`endif

    // 2: single word latency
    din = 8'hA5; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("lat_empty_after_e0", int'(empty), 1);
    step();
    check("lat_empty_after_e1", int'(empty), 0);
    check("lat_dout_after_e1", int'(dout), 8'hA5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("lat_empty_after_pop", int'(empty), 1);

    // 3: overfill; the sixth word is dropped
    for (int i = 1; i <= 6; i++) begin
      din = 8'(i); wr_en = 1'b1;
      step();
      if (i == 5) check("full_after_5th", int'(full), 1);
    end
    wr_en = 1'b0;
    check("full_after_6th", int'(full), 1);
`ifdef FIFO_FWFT_LEVEL_EN
    check("level_full", int'(level), 5);
`endif
    rd_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      check("drain_order", int'(dout), i);
      step();
    end
    rd_en = 1'b0;
    check("drain_empty", int'(empty), 1);

    // 4: reads while empty are ignored
    rd_en = 1'b1;
    repeat (10) begin
      step();
      check("empty_read_empty", int'(empty), 1);
    end
    rd_en = 1'b0;

    // 5: steady-state streaming with two words held
    din = 8'h10; wr_en = 1'b1; step();
    din = 8'h11; step();
    wr_en = 1'b0;
    repeat (2) step();
    wr_en = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 8'($urandom);
      step();
`ifdef FIFO_FWFT_LEVEL_EN
      check("stream_level", int'(level), 2);
`endif
      check("stream_full", int'(full), 0);
    end
    wr_en = 1'b0;
    guard = 0;
    while (!empty && guard < 20) begin step(); guard++; end
    rd_en = 1'b0;
    check("stream_drained", int'(empty), 1);

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      din = 8'hC0 + 8'(i); wr_en = 1'b1; step();
    end
    wr_en = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    check("arst_empty", int'(empty), 1);
    check("arst_full", int'(full), 0);
    check("arst_dout", int'(dout), 0);
    step();
    rst = 1'b0;
    din = 8'h5A; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    check("arst_new_empty", int'(empty), 0);
    check("arst_new_dout", int'(dout), 8'h5A);
    rd_en = 1'b1; step(); rd_en = 1'b0;

    // Random traffic: writer and reader each active about half the time
    target = accepted + 1000;
    guard  = 0;
    while (accepted < target && guard < 20000) begin
      wr_en = $urandom_range(0, 1) == 1;
      rd_en = $urandom_range(0, 1) == 1;
      din   = 8'($urandom);
      step();
      guard++;
    end
    check("random_words_accepted", int'(accepted >= target), 1);
    wr_en = 1'b0; rd_en = 1'b1;
    guard = 0;
    while (!empty && guard < 20) begin step(); guard++; end
    rd_en = 1'b0;
    step();
    check("random_drain_empty", int'(empty), 1);
    check("random_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
